// File: rtl/window_generator_fp16.sv
// window_generator_fp16
//   Streaming sliding-window former for FP16 raster-order pixels.
//   Holds WINDOW_HEIGHT-1 line buffers (IMAGE_WIDTH deep, addressed by column)
//   and a WINDOW_HEIGHT x WINDOW_WIDTH shift-register window. Outputs are
//   registered with a latency of one valid cycle.
//   Optional build macro: WINDOW_GENERATOR_EDGE_VALID_EN
//     defined   -> every pixel produces a window, with top/left zero padding
//     undefined -> only windows lying fully inside the frame are flagged valid
module window_generator_fp16 #(
   parameter int unsigned EXP_WIDTH     = 5,
   parameter int unsigned FRAC_WIDTH    = 10,
   parameter int unsigned FP_WIDTH_REG  = 1 + FRAC_WIDTH + EXP_WIDTH,
   parameter int unsigned WINDOW_WIDTH  = 2,
   parameter int unsigned WINDOW_HEIGHT = 1,
   parameter int unsigned IMAGE_WIDTH   = 640,
   parameter int unsigned IMAGE_HEIGHT  = 480
) (
   input  logic                                                         clk_i,
   input  logic                                                         rst_i,
   input  logic [FP_WIDTH_REG-1:0]                                      data_i,
   input  logic                                                         valid_i,
   output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
   output logic [15:0]                                                  col_o,
   output logic [15:0]                                                  row_o,
   output logic                                                         valid_o
);

   localparam int unsigned ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

   logic [15:0]                                                  col_q;
   logic [15:0]                                                  row_q;
   logic [ADDR_W-1:0]                                            addr;
   logic                                                         col_last;
   logic                                                         row_last;
   logic                                                         qual;
   logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0]                   tap;
   logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_nxt;

   assign addr     = col_q[ADDR_W-1:0];
   assign col_last = (col_q == 16'(IMAGE_WIDTH - 1));
   assign row_last = (row_q == 16'(IMAGE_HEIGHT - 1));

   // newest pixel always enters the bottom row of the window
   assign tap[WINDOW_HEIGHT-1] = data_i;

   generate
      if (WINDOW_HEIGHT > 1) begin : g_lb
         logic [WINDOW_HEIGHT-2:0][FP_WIDTH_REG-1:0] lb_rd;

         // chain of line buffers: stage k holds the row k+1 lines above the current one
         for (genvar k = 0; k < WINDOW_HEIGHT - 1; k++) begin : g_stage
            logic [FP_WIDTH_REG-1:0] mem [IMAGE_WIDTH];
            logic [FP_WIDTH_REG-1:0] wr;

            if (k == 0) begin : g_first
               assign wr = data_i;
            end else begin : g_next
               assign wr = lb_rd[k-1];
            end

            // asynchronous read returns the old word on the same edge that overwrites it
            assign lb_rd[k] = mem[addr];

            // write this stage on every accepted pixel; reset drops the pixel
            always_ff @(posedge clk_i) begin
               if (!rst_i && valid_i) begin
                  mem[addr] <= wr;
               end
            end
         end

         for (genvar i = 0; i < WINDOW_HEIGHT - 1; i++) begin : g_tap
            assign tap[i] = lb_rd[WINDOW_HEIGHT-2-i];
         end
      end
   endgenerate

   // next window: shift columns left and load the fetched column on the right
   always_comb begin
      win_nxt = window_o;
      for (int unsigned i = 0; i < WINDOW_HEIGHT; i++) begin
         for (int unsigned j = 0; j + 1 < WINDOW_WIDTH; j++) begin
            win_nxt[i][j] = window_o[i][j+1];
         end
         win_nxt[i][WINDOW_WIDTH-1] = tap[i];
      end
`ifdef WINDOW_GENERATOR_EDGE_VALID_EN
      // positions above/left of the frame are padded with +0.0; masking the whole
      // next window also clears columns shifted in from the previous row's tail
      for (int unsigned i = 0; i < WINDOW_HEIGHT; i++) begin
         for (int unsigned j = 0; j < WINDOW_WIDTH; j++) begin
            if ((row_q < 16'(WINDOW_HEIGHT - 1 - i)) || (col_q < 16'(WINDOW_WIDTH - 1 - j))) begin
               win_nxt[i][j] = '0;
            end
         end
      end
`endif
   end

`ifdef WINDOW_GENERATOR_EDGE_VALID_EN
   assign qual = 1'b1;
`else
   assign qual = (col_q >= 16'(WINDOW_WIDTH - 1)) && (row_q >= 16'(WINDOW_HEIGHT - 1));
`endif

   // raster counters and registered window outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         window_o <= '0;
         col_o    <= '0;
         row_o    <= '0;
         valid_o  <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         valid_o <= 1'b0;
         if (valid_i) begin
            window_o <= win_nxt;
            col_o    <= col_q;
            row_o    <= row_q;
            valid_o  <= qual;
            if (col_last) begin
               col_q <= '0;
               if (row_last) begin
                  row_q <= '0;
               end else begin
                  row_q <= row_q + 16'd1;
               end
            end else begin
               col_q <= col_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: doc/window_generator_fp16.md
Name: window_generator_fp16

Overview:
- Streaming sliding-window former placed directly upstream of the convolution stages (e.g. v_w_adder_*).
- Accepts one FP16 pixel per valid cycle in raster order.
- Holds WINDOW_HEIGHT-1 line buffers and a WINDOW_HEIGHT x WINDOW_WIDTH shift-register window.
- Emits window_o / col_o / row_o / valid_o in exactly the form the convolution block's window_i / col_i / row_i / valid_i consume.

Parameters:
EXP_WIDTH, 5, exponent bits.
FRAC_WIDTH, 10, fraction bits.
FP_WIDTH_REG, 1+FRAC_WIDTH+EXP_WIDTH, pixel word width.
WINDOW_WIDTH, 2, window columns (>=1).
WINDOW_HEIGHT, 1, window rows (>=1); 1 means no line buffers are generated.
IMAGE_WIDTH, 640, pixels per row (>= WINDOW_WIDTH).
IMAGE_HEIGHT, 480, rows per frame (>= WINDOW_HEIGHT).

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
rst_i  in  1  synchronous, active-high reset.
data_i  in  FP_WIDTH_REG  raster-order pixel.
valid_i  in  1  data_i is valid this cycle; no backpressure exists.
window_o  out  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  window; [H-1][W-1] is the newest pixel.
col_o  out  16  column of the newest pixel.
row_o  out  16  row of the newest pixel.
valid_o  out  1  window_o / col_o / row_o are valid.

Behaviour:
Reset (rst_i=1 at a clock edge):
- window_o all 0, col_o=0, row_o=0, valid_o=0.
- Internal col/row counters set to 0.
- Line-buffer RAM is not cleared; stale contents are never exposed (see masking).

Counters (advance only on valid_i):
- col increments each valid pixel; at IMAGE_WIDTH-1 it wraps to 0 and row increments.
- At col=IMAGE_WIDTH-1 and row=IMAGE_HEIGHT-1, both wrap to 0 (next frame).
- No idle-cycle or frame-gap requirements.

Column fetch (pixel p at (r,c), valid_i=1):
- tap[H-1]=data_i; tap[H-2]=lb0[c]; tap[H-1-k]=lb(k-1)[c] for k=1..H-1.
- Same edge writes: lb0[c]<=data_i, lbk[c]<=lb(k-1)[c] (read-before-write on the same address).
- Line buffers are IMAGE_WIDTH deep, addressed by col, one read and one write per valid cycle.

Window shift (each valid_i):
- window[i][j]<=window[i][j+1] for j<W-1.
- window[i][W-1]<=tap[i].

Output timing:
- Registered, latency 1: window_o, col_o=c, row_o=r and valid_o all update on the edge that consumes p.
- valid_o is high for exactly one cycle per qualifying pixel.
- With valid_i=0: valid_o=0, and window_o / col_o / row_o hold their values.

valid_o qualification (default):
- Only when c>=WINDOW_WIDTH-1 and r>=WINDOW_HEIGHT-1, i.e. the window lies fully inside the frame.
- Windows straddling a row wrap are therefore never flagged valid.
- Per frame: (IMAGE_WIDTH-W+1)*(IMAGE_HEIGHT-H+1) valid outputs.

Degenerate case W=1, H=1:
- window_o = registered data_i; valid every pixel.

Reset mid-frame:
- Counters restart; the next pixel is (0,0).
- Partially filled line buffers are masked by the row qualification.
- Reset has priority over a simultaneous valid_i (that pixel is dropped).

Optional Feature:
Macro WINDOW_GENERATOR_EDGE_VALID_EN.
- Defined:
  - valid_o is asserted for every input pixel (IMAGE_WIDTH*IMAGE_HEIGHT per frame).
  - Taps are zeroed (all-zero word, +0.0) where c-(W-1-j)<0 or r-(H-1-i)<0, i.e. top/left zero padding.
  - col_o / row_o still report the newest pixel.
- Undefined: default qualification, no masking logic synthesised.

Test Plan:
1. W=2, H=1, IMAGE_WIDTH=4, IMAGE_HEIGHT=2; stream 3C00,4000,4200,4400 back-to-back -> valid_o on 3 cycles: {3C00,4000} col1, {4000,4200} col2, {4200,4400} col3, all row0. No output for col0; the second row repeats the pattern at row_o=1.
2. W=3, H=3, IMAGE_WIDTH=4, IMAGE_HEIGHT=3; pixels 1..12 (value = index) -> first valid_o at (row2,col2) with rows {1,2,3},{5,6,7},{9,10,11}; second at col3 with {2,3,4},{6,7,8},{10,11,12}. No other valids in the frame.
3. Case 1 with valid_i deasserted for 3 cycles between every pixel -> identical output sequence. Outputs hold during gaps; valid_o is a single-cycle pulse per output.
4. Case 2 for two consecutive frames -> counters wrap to (0,0) after pixel 12. Frame 2 produces the same 2 windows with new data and no frame-1 row leakage.
5. Case 2 with rst_i pulsed after pixel 6, then 12 new pixels -> all outputs 0 after reset. Outputs then match a fresh frame; the simultaneous pixel on the reset edge is ignored.
6. WINDOW_GENERATOR_EDGE_VALID_EN defined, case 2 -> 12 valid_o pulses. At (0,0) the window is all 0 except [2][2]=1. At (1,3) window rows are {0,0,0},{2,3,4},{6,7,8}.
